// File: rtl/nfc_ecc_hamming_if.sv
// Sector ECC engine bus: byte stream in, stored ECC in, code and check result out.
interface nfc_ecc_hamming_if #(
    parameter int ADDR_W = 8
);
    localparam int E = 2 * ADDR_W + 6;

    logic              start;
    logic              mode;
    logic              din_valid;
    logic [7:0]        din;
    logic              din_ready;
    logic              ecc_in_valid;
    logic [E-1:0]      ecc_in;
    logic              busy;
    logic              done;
    logic [E-1:0]      ecc_out;
    logic [1:0]        status;
    logic [ADDR_W-1:0] err_byte;
    logic [2:0]        err_bit;

    modport master (
        output start, mode, din_valid, din, ecc_in_valid, ecc_in,
        input  din_ready, busy, done, ecc_out, status, err_byte, err_bit
    );

    modport slave (
        input  start, mode, din_valid, din, ecc_in_valid, ecc_in,
        output din_ready, busy, done, ecc_out, status, err_byte, err_bit
    );
endinterface

// File: rtl/nfc_ecc_hamming.sv
// Hamming line/column parity ECC over one NAND sector; encodes on program,
// classifies the stored code on read (clean / 1-bit data / ECC field / uncorrectable).
module nfc_ecc_hamming #(
    parameter int ADDR_W = 8
) (
    input  logic               ACLK,
    input  logic               ARESET,
    nfc_ecc_hamming_if.slave   bus
);
    localparam int E = 2 * ADDR_W + 6;

    typedef enum logic [2:0] {IDLE, ACCUM, FINISH, WAIT_ECC, EVAL} state_t;

    state_t            state, state_nxt;
    logic              mode_r;
    logic [ADDR_W-1:0] addr_p0;
    logic [E-1:0]      acc_p0;
    logic [E-1:0]      acc_sum;
    logic              vld_p0;
    logic              last_p0;
    logic [E-1:0]      ecc_p1;
    logic [1:0]        status_p1;
    logic [ADDR_W-1:0] err_byte_p1;
    logic [2:0]        err_bit_p1;

    // Contribution of one byte at address adr: row parity steered by each
    // address bit, column parities split on each bit-index bit.
    function automatic logic [E-1:0] byte_code(input logic [7:0] d,
                                               input logic [ADDR_W-1:0] adr);
        logic [E-1:0] c;
        logic         p;
        c = '0;
        p = ^d;
        for (int k = 0; k < ADDR_W; k++) begin
            if (adr[k]) c[2*k+1] = p;
            else        c[2*k]   = p;
        end
        c[2*ADDR_W+1] = ^(d & 8'hAA);
        c[2*ADDR_W]   = ^(d & 8'h55);
        c[2*ADDR_W+3] = ^(d & 8'hCC);
        c[2*ADDR_W+2] = ^(d & 8'h33);
        c[2*ADDR_W+5] = ^(d & 8'hF0);
        c[2*ADDR_W+4] = ^(d & 8'h0F);
        return c;
    endfunction

    // Returns {status, err_byte, err_bit}; location fields only for a single data bit.
    function automatic logic [ADDR_W+4:0] decode(input logic [E-1:0] s);
        logic              single;
        logic [1:0]        st;
        logic [ADDR_W-1:0] eb;
        logic [2:0]        ebit;
        single = 1'b1;
        eb     = '0;
        ebit   = '0;
        for (int i = 0; i < ADDR_W + 3; i++)
            single = single & (s[2*i+1] ^ s[2*i]);
        if (s == '0) begin
            st = 2'b00;
        end else if (single) begin
            st = 2'b01;
            for (int k = 0; k < ADDR_W; k++) eb[k] = s[2*k+1];
            for (int j = 0; j < 3; j++) ebit[j] = s[2*ADDR_W+2*j+1];
        end else if ($countones(s) == 1) begin
            st = 2'b10;
        end else begin
            st = 2'b11;
        end
        return {st, eb, ebit};
    endfunction

    assign vld_p0  = (state == ACCUM) && bus.din_valid && !bus.start;
    assign last_p0 = &addr_p0;
    assign acc_sum = acc_p0 ^ byte_code(bus.din, addr_p0);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                IDLE:     state_nxt = IDLE;
                ACCUM:    if (vld_p0 && last_p0) state_nxt = mode_r ? WAIT_ECC : FINISH;
                WAIT_ECC: if (bus.ecc_in_valid) state_nxt = EVAL;
                FINISH:   state_nxt = IDLE;
                EVAL:     state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.din_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state)
            IDLE:     bus.busy = 1'b0;
            ACCUM:    begin bus.busy = 1'b1; bus.din_ready = 1'b1; end
            WAIT_ECC: bus.busy = 1'b1;
            FINISH:   begin bus.busy = 1'b1; bus.done = 1'b1; end
            EVAL:     begin bus.busy = 1'b1; bus.done = 1'b1; end
            default:  bus.busy = 1'b1;
        endcase
    end

    // Stage p0: accumulate accepted bytes
    always_ff @(posedge ACLK) begin
        if (bus.start)   acc_p0 <= '0;
        else if (vld_p0) acc_p0 <= acc_sum;
    end

    // Stage p1: latch the inverted code and the check result
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mode_r      <= 1'b0;
            addr_p0     <= '0;
            ecc_p1      <= '1;
            status_p1   <= 2'b00;
            err_byte_p1 <= '0;
            err_bit_p1  <= '0;
        end else if (bus.start) begin
            mode_r      <= bus.mode;
            addr_p0     <= '0;
            status_p1   <= 2'b00;
            err_byte_p1 <= '0;
            err_bit_p1  <= '0;
        end else begin
            if (vld_p0) begin
                addr_p0 <= addr_p0 + 1'b1;
                if (last_p0) ecc_p1 <= ~acc_sum;
            end
            if (state == WAIT_ECC && bus.ecc_in_valid)
                {status_p1, err_byte_p1, err_bit_p1} <= decode(bus.ecc_in ^ ecc_p1);
        end
    end

    assign bus.ecc_out  = ecc_p1;
    assign bus.status   = status_p1;
    assign bus.err_byte = err_byte_p1;
    assign bus.err_bit  = err_bit_p1;
endmodule
